// File: rtl/pwm_softstart.sv
// pwm_softstart -- buck-converter gate driver with soft start and dead time.
//
// Consumes a one-cycle tick from the upstream clock-divider stage. A period
// counter advancing on tick sets the PWM ratio. Duty ramps from 0 to the
// target (soft start) before regulation. A fault forces both gates off and
// latches until enable and fault are both low.
//
// Ports:
//   original_clk  system clock
//   reset         synchronous, active-high reset
//   tick          single-cycle enable for the period counter
//   enable        1 = run converter, 0 = shut down
//   duty_target   requested duty (high-side on-ticks per period)
//   fault         level-sensitive over-current / over-voltage flag
//   hs_gate       high-side gate drive (registered)
//   ls_gate       low-side gate drive (registered)
//   period_start  one-cycle pulse after the counter wraps to 0
//   ramp_done     high while regulating (soft start finished)
//   fault_latched high while the fault latch holds
module pwm_softstart #(
  parameter int WIDTH     = 8,
  parameter int DEADTIME  = 2,
  parameter int RAMP_STEP = 1
) (
  input  logic             original_clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty_target,
  input  logic             fault,
  output logic             hs_gate,
  output logic             ls_gate,
  output logic             period_start,
  output logic             ramp_done,
  output logic             fault_latched
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RAMP  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  // Which gate the dead-time logic is currently heading towards.
  localparam logic [1:0] GATE_NONE = 2'd0;
  localparam logic [1:0] GATE_HS   = 2'd1;
  localparam logic [1:0] GATE_LS   = 2'd2;

  localparam int DT_W = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  localparam logic [DT_W-1:0]  DT_LOAD  = DT_W'(DEADTIME);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(RAMP_STEP);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [DT_W-1:0]  dt_q, dt_d;
  logic [1:0]       sel_q, sel_d;
  logic             hs_q, hs_d;
  logic             ls_q, ls_d;
  logic             ps_q, ps_d;

  logic             running_q;
  logic             running_d;
  logic             wrap;
  logic [WIDTH:0]   duty_sum;
  logic [WIDTH-1:0] ramp_duty;
  logic             pwm_raw;
  logic [1:0]       want;

  always_comb begin
    running_q = (state_q == ST_RAMP) || (state_q == ST_RUN);
    wrap      = running_q && tick && (cnt_q == CNT_MAX);

    // One extra bit so duty + step can never wrap around before the clamp.
    duty_sum  = {1'b0, duty_q} + STEP_EXT;
    ramp_duty = (duty_sum > {1'b0, duty_target}) ? duty_target : duty_sum[WIDTH-1:0];

    // Next state: fault beats enable, enable beats ramp completion.
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && !fault) state_d = ST_RAMP;
      end
      ST_RAMP: begin
        if (fault)                                  state_d = ST_FAULT;
        else if (!enable)                           state_d = ST_IDLE;
        else if (wrap && (ramp_duty == duty_target)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (fault)        state_d = ST_FAULT;
        else if (!enable) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (!enable && !fault) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    running_d = (state_d == ST_RAMP) || (state_d == ST_RUN);

    // Period counter and duty; duty only moves on the wrapping tick so a
    // period is never cut short or stretched by an update.
    cnt_d  = cnt_q;
    duty_d = duty_q;
    if (!running_d) begin
      cnt_d  = '0;
      duty_d = '0;
    end else if (running_q && tick) begin
      cnt_d = cnt_q + 1'b1;
      if (wrap) duty_d = (state_q == ST_RAMP) ? ramp_duty : duty_target;
    end
    ps_d = wrap && running_d;

    // Gate selection with dead time. Shutdown is keyed off the next state so
    // the gates drop one cycle after fault/disable is sampled.
    pwm_raw = (cnt_q < duty_q);
    want    = pwm_raw ? GATE_HS : GATE_LS;
    if (!running_d) begin
      sel_d = GATE_NONE;
      dt_d  = '0;
    end else if (want != sel_q) begin
      // New direction (or a flip back mid dead time): restart the gap.
      sel_d = want;
      dt_d  = DT_LOAD;
    end else begin
      sel_d = sel_q;
      dt_d  = (dt_q != '0) ? dt_q - 1'b1 : '0;
    end
    hs_d = running_d && (dt_d == '0) && (sel_d == GATE_HS);
    ls_d = running_d && (dt_d == '0) && (sel_d == GATE_LS);
  end

  always_ff @(posedge original_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      dt_q    <= '0;
      sel_q   <= GATE_NONE;
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
      ps_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      dt_q    <= dt_d;
      sel_q   <= sel_d;
      hs_q    <= hs_d;
      ls_q    <= ls_d;
      ps_q    <= ps_d;
    end
  end

  assign hs_gate       = hs_q;
  assign ls_gate       = ls_q;
  assign period_start  = ps_q;
  assign ramp_done     = (state_q == ST_RUN);
  assign fault_latched = (state_q == ST_FAULT);

endmodule

// File: tb/tb_pwm_softstart.sv
// tb_pwm_softstart -- self-checking bench for pwm_softstart (WIDTH=4,
// DEADTIME=2, tick every 3rd cycle). A second instance with RAMP_STEP=4
// shares all inputs and is used for the coarse-step ramp scenario.
module tb_pwm_softstart;

  localparam int W    = 4;
  localparam int DT   = 2;
  localparam int TDIV = 3;
  localparam int PER  = (1 << W) * TDIV;

  logic         clk;
  logic         reset;
  logic         tick;
  logic         enable;
  logic         fault;
  logic [W-1:0] duty_target;

  logic hs, ls, ps, rd, fl;
  logic hs2, ls2, ps2, rd2, fl2;

  int errors = 0;
  int checks = 0;
  int phase  = 0;

  pwm_softstart #(.WIDTH(W), .DEADTIME(DT), .RAMP_STEP(1)) dut (
    .original_clk (clk),
    .reset        (reset),
    .tick         (tick),
    .enable       (enable),
    .duty_target  (duty_target),
    .fault        (fault),
    .hs_gate      (hs),
    .ls_gate      (ls),
    .period_start (ps),
    .ramp_done    (rd),
    .fault_latched(fl)
  );

  pwm_softstart #(.WIDTH(W), .DEADTIME(DT), .RAMP_STEP(4)) dut2 (
    .original_clk (clk),
    .reset        (reset),
    .tick         (tick),
    .enable       (enable),
    .duty_target  (duty_target),
    .fault        (fault),
    .hs_gate      (hs2),
    .ls_gate      (ls2),
    .period_start (ps2),
    .ramp_done    (rd2),
    .fault_latched(fl2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Upstream divider stand-in: one-cycle tick every TDIV cycles.
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      phase = (phase + 1) % TDIV;
      tick  = (phase == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Expected high-side on-cycles per period for a given duty: pwm_raw is
  // high for duty ticks of TDIV cycles each, and entry into high side
  // loses DT cycles of dead time.
  function automatic int exp_hs(input int d);
    return (d == 0) ? 0 : d * TDIV - DT;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits for a period_start pulse on the chosen instance, then counts gate
  // cycles over the next full period. Optionally changes duty_target at
  // sample chg_idx of the window.
  task automatic measure(input int which, input int chg_idx, input int chg_val,
                         output int waited, output int hs_n, output int ls_n,
                         output logic rd_start);
    logic p;
    waited = 0;
    p      = 1'b0;
    while (!p && waited < 200) begin
      @(negedge clk);
      waited++;
      p = (which == 0) ? ps : ps2;
    end
    rd_start = (which == 0) ? rd : rd2;
    hs_n = 0;
    ls_n = 0;
    for (int i = 0; i < PER; i++) begin
      if (i > 0) @(negedge clk);
      if (i == chg_idx) duty_target = chg_val[W-1:0];
      hs_n += (which == 0) ? int'(hs) : int'(hs2);
      ls_n += (which == 0) ? int'(ls) : int'(ls2);
    end
  endtask

  task automatic test_reset();
    int pulses;
    reset = 1'b1; enable = 1'b0; fault = 1'b0; duty_target = '0;
    step(3);
    reset = 1'b0;
    step(1);
    checks++;
    if ({hs, ls, ps, rd, fl} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000", {hs, ls, ps, rd, fl});
    end
    checks++;
    if ({hs2, ls2, ps2, rd2, fl2} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs2: got %b want 00000", {hs2, ls2, ps2, rd2, fl2});
    end
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      pulses += int'(ps) + int'(hs) + int'(ls);
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d active samples want 0", pulses);
    end
    $display("reset: outputs low, idle quiet");
  endtask

  task automatic test_soft_start();
    int waited, hs_n, ls_n, d;
    logic r;
    duty_target = 4'd3;
    enable = 1'b1;
    step(2);
    checks++;
    if ({hs, ls} !== 2'b00) begin
      errors++;
      $display("FAIL entry_deadtime: got hs,ls=%b want 00", {hs, ls});
    end
    step(1);
    checks++;
    if ({hs, ls} !== 2'b01) begin
      errors++;
      $display("FAIL entry_ls: got hs,ls=%b want 01", {hs, ls});
    end
    d = 0;
    for (int k = 0; k < 4; k++) begin
      d = min_i(d + 1, 3);
      measure(0, -1, 0, waited, hs_n, ls_n, r);
      checks++;
      if ((k == 0) ? (waited >= 60) : (waited !== 1)) begin
        errors++;
        $display("FAIL ss_spacing k=%0d: got wait %0d", k, waited);
      end
      checks++;
      if (hs_n !== exp_hs(d)) begin
        errors++;
        $display("FAIL ss_hs k=%0d: got %0d want %0d", k, hs_n, exp_hs(d));
      end
      checks++;
      if (r !== (d == 3)) begin
        errors++;
        $display("FAIL ss_ramp_done k=%0d: got %b want %b", k, r, (d == 3));
      end
      $display("soft_start window %0d: duty %0d hs %0d ramp_done %b", k, d, hs_n, r);
    end
  endtask

  task automatic test_target_change();
    int waited, hs_n, ls_n;
    logic r;
    measure(0, 10, 10, waited, hs_n, ls_n, r);
    checks++;
    if (hs_n !== exp_hs(3) || waited !== 1) begin
      errors++;
      $display("FAIL tc_hold: got hs %0d wait %0d want %0d 1", hs_n, waited, exp_hs(3));
    end
    measure(0, 10, 0, waited, hs_n, ls_n, r);
    checks++;
    if (hs_n !== exp_hs(10)) begin
      errors++;
      $display("FAIL tc_ten: got hs %0d want %0d", hs_n, exp_hs(10));
    end
    measure(0, -1, 0, waited, hs_n, ls_n, r);
    checks++;
    if (hs_n !== 0 || ls_n !== PER || r !== 1'b1) begin
      errors++;
      $display("FAIL tc_zero: got hs %0d ls %0d rd %b want 0 %0d 1", hs_n, ls_n, r, PER);
    end
    $display("target_change: 3->10->0 applied at period boundaries");
  endtask

  task automatic test_fault();
    int bad, waited, hs_n, ls_n;
    logic r;
    @(negedge clk);
    fault = 1'b1;
    @(negedge clk);
    checks++;
    if ({hs, ls, fl, rd} !== 4'b0010) begin
      errors++;
      $display("FAIL fault_entry: got hs,ls,fl,rd=%b want 0010", {hs, ls, fl, rd});
    end
    fault = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (hs || ls || ps || !fl) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL fault_hold: got %0d bad samples want 0", bad);
    end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (fl !== 1'b0) begin
      errors++;
      $display("FAIL fault_release: got fault_latched %b want 0", fl);
    end
    duty_target = 4'd3;
    enable = 1'b1;
    measure(0, -1, 0, waited, hs_n, ls_n, r);
    checks++;
    if (hs_n !== exp_hs(1) || r !== 1'b0 || waited >= 60) begin
      errors++;
      $display("FAIL fault_rearm: got hs %0d rd %b wait %0d want %0d 0 <60", hs_n, r, waited, exp_hs(1));
    end
    $display("fault: latched, released, soft start restarted");
  endtask

  task automatic test_reset_mid_run();
    int n, waited, hs_n, ls_n;
    logic r;
    n = 0;
    while (!(hs && rd) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL rst_reach_run: got timeout want hs=1 in RUN");
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({hs, ls, ps, rd, fl, hs2, ls2, ps2, rd2, fl2} !== 10'b0) begin
      errors++;
      $display("FAIL rst_mid_run: got %b want all 0", {hs, ls, ps, rd, fl, hs2, ls2, ps2, rd2, fl2});
    end
    reset = 1'b0;
    measure(0, -1, 0, waited, hs_n, ls_n, r);
    checks++;
    if (hs_n !== exp_hs(1) || r !== 1'b0) begin
      errors++;
      $display("FAIL rst_restart: got hs %0d rd %b want %0d 0", hs_n, r, exp_hs(1));
    end
    $display("reset_mid_run: outputs cleared, ramp restarted");
  endtask

  task automatic test_boundaries();
    int bad, waited, hs_n, ls_n, d;
    logic r;
    // Disable during RAMP.
    step(5);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({hs, ls, rd} !== 3'b000) begin
      errors++;
      $display("FAIL ramp_disable: got hs,ls,rd=%b want 000", {hs, ls, rd});
    end
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (hs || ls || ps) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL ramp_disable_hold: got %0d active samples want 0", bad);
    end
    // Coarse ramp step on the second instance: no overshoot past target.
    duty_target = 4'd14;
    enable = 1'b1;
    pulse_reset();
    d = 0;
    for (int k = 0; k < 5; k++) begin
      d = min_i(d + 4, 14);
      measure(1, -1, 0, waited, hs_n, ls_n, r);
      checks++;
      if (hs_n !== exp_hs(d) || r !== (d == 14)) begin
        errors++;
        $display("FAIL step4 k=%0d: got hs %0d rd %b want %0d %b", k, hs_n, r, exp_hs(d), (d == 14));
      end
      $display("step4 window %0d: duty %0d hs %0d ramp_done %b", k, d, hs_n, r);
    end
    // Maximum duty.
    duty_target = 4'd15;
    pulse_reset();
    d = 0;
    for (int k = 0; k < 16; k++) begin
      d = min_i(d + 1, 15);
      measure(0, -1, 0, waited, hs_n, ls_n, r);
      checks++;
      if (hs_n !== exp_hs(d) || r !== (d == 15)) begin
        errors++;
        $display("FAIL max_duty k=%0d: got hs %0d rd %b want %0d %b", k, hs_n, r, exp_hs(d), (d == 15));
      end
    end
    $display("boundaries: disable in ramp, step 4 to 14, duty 15 -> hs %0d", hs_n);
  endtask

  task automatic test_random();
    int cur_exp, next_exp, hs_acc, widx, prev_g, zrun, g, windows;
    duty_target = 4'd1;
    enable = 1'b1;
    pulse_reset();
    cur_exp  = -1;
    next_exp = 1;
    hs_acc = 0; widx = 0; prev_g = 0; zrun = 0; windows = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      checks++;
      if ((hs & ls) !== 1'b0) begin
        errors++;
        $display("FAIL overlap c=%0d: got hs&ls=%b want 0", c, hs & ls);
      end
      g = hs ? 1 : (ls ? 2 : 0);
      if (g == 0) begin
        zrun++;
      end else begin
        if (prev_g != 0 && prev_g != g) begin
          checks++;
          if (zrun !== DT) begin
            errors++;
            $display("FAIL deadtime c=%0d: got %0d off cycles want %0d", c, zrun, DT);
          end
        end
        prev_g = g;
        zrun = 0;
      end
      if (ps) begin
        if (cur_exp >= 0) begin
          checks++;
          windows++;
          if (hs_acc !== exp_hs(cur_exp)) begin
            errors++;
            $display("FAIL rand_window c=%0d: got hs %0d want %0d (duty %0d)", c, hs_acc, exp_hs(cur_exp), cur_exp);
          end
        end
        cur_exp = next_exp;
        hs_acc = 0;
        widx = 0;
      end
      hs_acc += int'(hs);
      widx++;
      if (cur_exp >= 0 && widx == 20) begin
        next_exp = int'($urandom_range(0, 15));
        duty_target = W'(next_exp);
      end
    end
    checks++;
    if (windows < 30) begin
      errors++;
      $display("FAIL rand_windows: got %0d full periods want >= 30", windows);
    end
    $display("random: %0d periods checked", windows);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    fault = 1'b0;
    duty_target = '0;
    test_reset();
    test_soft_start();
    test_target_change();
    test_fault();
    test_reset_mid_run();
    test_boundaries();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_softstart.md
Name: pwm_softstart

Overview:
- Buck-converter gate driver: consumes the one-cycle `tick` pulse from the slow_clk stage, which sits directly upstream.
- Generates complementary high-side/low-side PWM gate signals with programmable dead time.
- Ramps duty from 0 to a target value (soft start) before entering regulation.
- A fault input forces both gates off until the block is re-armed.

Parameters:
- WIDTH, 8, width of the period counter and duty values; period = 2^WIDTH ticks.
- DEADTIME, 2, original_clk cycles with both gates off at every gate transition; 0 disables dead time.
- RAMP_STEP, 1, duty increment applied per PWM period during soft start.

Ports:
- original_clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  single-cycle enable pulse from slow_clk; the period counter advances only when tick=1.
- enable  input  1  level; 1 = run converter, 0 = shut down.
- duty_target  input  WIDTH  requested steady-state duty; high-side on-ticks per period.
- fault  input  1  over-current/over-voltage flag, level-sensitive.
- hs_gate  output  1  high-side switch drive, registered.
- ls_gate  output  1  low-side (synchronous rectifier) drive, registered.
- period_start  output  1  one-cycle pulse when the counter wraps to 0.
- ramp_done  output  1  high while in RUN.
- fault_latched  output  1  high while in FAULT.

Behaviour:
- **Reset.** One cycle of reset=1 at a rising edge of original_clk. Afterwards:
  - state=IDLE; cnt=0; duty_cur=0; dead-time counter=0.
  - hs_gate=0, ls_gate=0, period_start=0, ramp_done=0, fault_latched=0.
  - Reset has priority over every other input and acts mid-operation.
- **Period counter.** cnt (WIDTH bits) advances only in RAMP or RUN, and only on a tick.
  - On tick, cnt increments and wraps from 2^WIDTH-1 to 0.
  - The wrap sets period_start=1 for exactly the following cycle.
  - In IDLE and FAULT, cnt is held at 0.
- **Raw PWM.** pwm_raw = (cnt < duty_cur).
  - duty_cur=0 gives a constant 0.
  - Maximum duty is (2^WIDTH-1)/2^WIDTH; 100% duty is not reachable by design.
- **Duty update.** duty_cur changes only on the tick that wraps cnt (period boundary). This makes updates glitch-free.
  - In RAMP: duty_cur <= min(duty_cur+RAMP_STEP, duty_target). Compute in WIDTH+1 bits so the sum cannot overflow.
  - If duty_target < duty_cur, duty_cur <= duty_target.
  - In RUN: duty_cur <= duty_target.
- **FSM.** States IDLE, RAMP, RUN, FAULT; evaluated every original_clk cycle. Priority order within a cycle: reset > fault > enable > ramp completion.
  - IDLE: enable=1 and fault=0 -> RAMP, with duty_cur=0 and cnt=0.
  - RAMP: fault=1 -> FAULT. Else enable=0 -> IDLE. Else, once duty_cur==duty_target after a period-boundary update -> RUN.
  - RAMP with duty_target=0: enters RUN at the first wrap.
  - RUN: fault=1 -> FAULT. Else enable=0 -> IDLE. RUN never returns to RAMP.
  - FAULT: fault_latched=1. Leaves to IDLE only when enable=0 and fault=0 in the same cycle. Re-enabling always restarts soft start from duty 0.
  - Entering IDLE or FAULT resets duty_cur to 0 and cnt to 0.
- **Gate logic.**
  - In IDLE and FAULT: hs_gate=0 and ls_gate=0 from the cycle after the state change (one-cycle latency). Any pending dead time is cancelled.
  - In RAMP/RUN, the desired gate is hs when pwm_raw=1, ls when pwm_raw=0.
  - When desired differs from the gate currently driven, both gates go to 0 for DEADTIME cycles, then the new gate asserts.
  - If desired flips back during dead time, the dead-time counter restarts.
  - On entry to RAMP, ls_gate asserts after DEADTIME cycles (duty_cur=0 at that point).
  - Invariant: hs_gate & ls_gate == 0 in every cycle.
- **Tick during dead time.** No special handling; the counter and the dead-time logic are independent.

Test Plan:
- Conditions: WIDTH=4, DEADTIME=2, RAMP_STEP=1; tick every 3rd cycle (CLOCKCOUNT=2 upstream).
- **Reset:** assert reset mid-RUN with hs_gate=1 -> next cycle all outputs 0 and state IDLE; hold enable=1 and release reset -> RAMP restarts from duty 0.
- **Soft start:** enable=1, duty_target=3 -> duty_cur goes 0,1,2,3 at successive wraps. ramp_done rises at the third wrap. hs high for 3 of 16 ticks per period thereafter. period_start pulses once every 48 cycles.
- **Dead time:** every hs<->ls transition shows exactly 2 cycles with both gates 0. A checker asserts hs_gate&ls_gate never 1 across 2000 random cycles with random duty_target.
- **Target change in RUN:** change duty_target 3->10 mid-period -> high time unchanged until the next wrap, then 10 ticks high; 10->0 -> hs never asserts, ls stays high.
- **Fault:** pulse fault for one cycle in RUN -> gates 0 next cycle and fault_latched=1. Stays latched with enable=1 after fault drops. Drop enable -> IDLE. Re-raise enable -> ramp restarts at duty 0.
- **Boundaries:** duty_target=15 -> hs high for 15 of 16 ticks. With RAMP_STEP=4 and target=14 -> duty goes 0,4,8,12,14 with no overshoot. enable=0 during RAMP -> IDLE with gates 0 in the next cycle.
